// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Opcode values live in the top nibble of each instruction word.
package pc_seq_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int OFF_W_DEF   = 8;
  localparam int OPC_W       = 4;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT,
    ST_FAULT
  } state_e;

  localparam logic [OPC_W-1:0] OP_BC   = 4'hA;
  localparam logic [OPC_W-1:0] OP_BN   = 4'hB;
  localparam logic [OPC_W-1:0] OP_BR   = 4'hC;
  localparam logic [OPC_W-1:0] OP_BZ   = 4'hD;
  localparam logic [OPC_W-1:0] OP_BNZ  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  function automatic logic is_halt_op(input logic [OPC_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Combinational branch evaluation: classifies the opcode and resolves
// the taken condition from the current datapath flags.
module branch_cond
  import pc_seq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_n,
  output logic             is_branch,
  output logic             taken
);

  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (opcode)
      OP_BC:   taken = flag_c;
      OP_BN:   taken = flag_n;
      OP_BR:   taken = 1'b1;
      OP_BZ:   taken = flag_z;
      OP_BNZ:  taken = !flag_z;
      default: is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM driving the PC counter's load/select,
// with instruction-memory and execute-unit handshakes guarded by a timeout.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OFF_W   = OFF_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               exec_valid,
  input  logic               exec_done,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic               flag_n,
  output logic               ld_pc,
  output logic               sel_pc,
  output logic [OFF_W-1:0]   pc_offset,
  output logic [INSTR_W-1:0] ir_out,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  // The wait that fails is the TIMEOUT-th consecutive missed handshake,
  // i.e. the one observed while the counter still holds TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               taken_q, taken_d;

  logic [OPC_W-1:0]   opcode;
  logic               is_branch;
  logic               cond_taken;
  logic               op_halt;

  assign opcode  = ir_q[INSTR_W-1 -: OPC_W];
  assign op_halt = is_halt_op(opcode);

  branch_cond u_branch_cond (
    .opcode    (opcode),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .is_branch (is_branch),
    .taken     (cond_taken)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        taken_d = cond_taken;
        state_d = (is_branch || op_halt) ? ST_UPDATE : ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        state_d = op_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  // Control outputs come straight from the state register so they never glitch.
  assign imem_req   = (state_q == ST_FETCH);
  assign exec_valid = (state_q == ST_EXEC);
  assign ld_pc      = (state_q == ST_UPDATE);
  assign sel_pc     = (state_q == ST_UPDATE) && taken_q;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_UPDATE);
  assign halted     = (state_q == ST_HALT);
  assign fault      = (state_q == ST_FAULT);
  assign pc_offset  = ir_q[OFF_W-1:0];
  assign ir_out     = ir_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: each instruction is planned as a
// transaction (ack wait, execute wait, flags) and the expected cycle trace is derived from it.
module tb_pc_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        exec_valid;
  logic        exec_done;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;
  logic        ld_pc;
  logic        sel_pc;
  logic [7:0]  pc_offset;
  logic [15:0] ir_out;
  logic        busy;
  logic        halted;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer #(.INSTR_W(16), .OFF_W(8), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .exec_valid (exec_valid),
    .exec_done  (exec_done),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_n     (flag_n),
    .ld_pc      (ld_pc),
    .sel_pc     (sel_pc),
    .pc_offset  (pc_offset),
    .ir_out     (ir_out),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Status bits in order: req, exec_valid, ld_pc, sel_pc, busy, halted, fault.
  task automatic chk_st(input string tag, input logic r, input logic ev, input logic ld,
                        input logic sel, input logic b, input logic h, input logic f);
    chk(tag, {9'd0, imem_req, exec_valid, ld_pc, sel_pc, busy, halted, fault},
             {9'd0, r, ev, ld, sel, b, h, f});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    flag_z     = 1'($urandom);
    flag_c     = 1'($urandom);
    flag_n     = 1'($urandom);
    imem_rdata = 16'($urandom);
  endtask

  function automatic logic exp_taken(input logic [3:0] op, input logic z, input logic c,
                                     input logic n);
    case (op)
      4'hA:    return c;
      4'hB:    return n;
      4'hC:    return 1'b1;
      4'hD:    return z;
      4'hE:    return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom % 4);
    if (r == 0) return 0;
    if (r == 1) return TO - 1;
    return int'($urandom_range(0, TO - 1));
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b1; imem_ack = 1'b1; exec_done = 1'b1;
    noise();
    tick();
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    chk_st("reset_st", 0, 0, 0, 0, 0, 0, 0);
    chk("reset_ir", ir_out, 16'h0000);
  endtask

  task automatic start_from_idle();
    chk_st("idle_st", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_fault_hold();
    for (int i = 0; i < 3; i++) begin
      chk_st("fault_st", 0, 0, 0, 0, 0, 0, 1);
      start = 1'b1; imem_ack = 1'($urandom); exec_done = 1'($urandom);
      noise();
      tick();
    end
    start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
  endtask

  task automatic fetch_timeout();
    for (int k = 0; k < TO; k++) begin
      chk_st("to_fetch_st", 1, 0, 0, 0, 1, 0, 0);
      imem_ack = 1'b0; exec_done = 1'($urandom); start = 1'($urandom);
      noise();
      tick();
    end
    $display("txn fetch-timeout after %0d waits", TO);
    check_fault_hold();
  endtask

  // mode 0: normal completion, 1: exec timeout, 2: reset asserted during EXEC.
  // zf < 0 leaves flag_z random on the decode cycle.
  task automatic run_instr(input logic [15:0] instr, input int d, input int e,
                           input int mode, input int zf);
    logic [3:0] op;
    logic       tk;
    int         h;
    op = instr[15:12];
    tk = 1'b0;
    for (int k = 0; k <= d; k++) begin
      chk_st("fetch_st", 1, 0, 0, 0, 1, 0, 0);
      noise();
      exec_done = 1'($urandom);
      start     = 1'($urandom);
      imem_ack  = (k == d);
      if (k == d) imem_rdata = instr;
      tick();
    end
    chk_st("decode_st", 0, 0, 0, 0, 1, 0, 0);
    chk("decode_ir", ir_out, instr);
    noise();
    if (zf >= 0) flag_z = zf[0];
    tk = exp_taken(op, flag_z, flag_c, flag_n);
    imem_ack = 1'($urandom); exec_done = 1'($urandom); start = 1'($urandom);
    tick();
    if (op < 4'hA) begin
      if (mode == 1) begin
        for (int k = 0; k < TO; k++) begin
          chk_st("to_exec_st", 0, 1, 0, 0, 1, 0, 0);
          exec_done = 1'b0; imem_ack = 1'($urandom); start = 1'($urandom);
          noise();
          tick();
        end
        $display("txn instr=%h exec-timeout after %0d waits", instr, TO);
        check_fault_hold();
        return;
      end
      for (int k = 0; k <= e; k++) begin
        chk_st("exec_st", 0, 1, 0, 0, 1, 0, 0);
        noise();
        imem_ack = 1'($urandom); start = 1'($urandom);
        if (mode == 2 && k == e) begin
          exec_done = 1'b0;
          rst = 1'b1;
        end else begin
          exec_done = (k == e);
        end
        tick();
      end
      if (mode == 2) begin
        rst = 1'b0; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        chk_st("rst_exec_st", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_exec_ir", ir_out, 16'h0000);
        chk("rst_exec_off", {8'd0, pc_offset}, 16'h0000);
        tick();
        chk_st("rst_exec_idle", 0, 0, 0, 0, 0, 0, 0);
        $display("txn instr=%h reset during exec cycle %0d", instr, e);
        return;
      end
    end
    chk_st("update_st", 0, 0, 1, tk, 1, 0, 0);
    chk("update_off", {8'd0, pc_offset}, {8'd0, instr[7:0]});
    noise();
    imem_ack = 1'($urandom); exec_done = 1'($urandom); start = 1'($urandom);
    tick();
    start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    $display("txn instr=%h ack_wait=%0d exec_wait=%0d taken=%0d", instr, d,
             (op < 4'hA) ? e : -1, tk);
    if (op == 4'hF) begin
      h = int'($urandom_range(1, 4));
      for (int i = 0; i < h; i++) begin
        chk_st("halt_st", 0, 0, 0, 0, 0, 1, 0);
        start = 1'b0; imem_ack = 1'($urandom); exec_done = 1'($urandom);
        noise();
        tick();
      end
      chk_st("halt_st", 0, 0, 0, 0, 0, 1, 0);
      start = 1'b1; imem_ack = 1'b0; exec_done = 1'b0;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] instr;
    int          n;
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    noise();

    do_reset();
    start_from_idle();
    run_instr(16'h1234, 0, 1, 0, -1);
    run_instr(16'hD0F0, 0, 0, 0, 1);
    run_instr(16'hD0F0, 2, 0, 0, 0);
    run_instr(16'hF000, 0, 0, 0, -1);
    fetch_timeout();

    do_reset();
    start_from_idle();
    run_instr(16'h5A5A, TO - 1, TO - 1, 0, -1);
    run_instr(16'h3001, 1, 0, 1, -1);

    do_reset();
    start_from_idle();
    run_instr(16'h7C3E, 0, 3, 2, -1);

    for (int ep = 0; ep < 9; ep++) begin
      do_reset();
      start_from_idle();
      n = int'($urandom_range(4, 12));
      for (int i = 0; i < n; i++) begin
        instr = 16'($urandom);
        run_instr(instr, pick_wait(), pick_wait(), 0, -1);
      end
      case (ep % 3)
        0: fetch_timeout();
        1: run_instr({4'($urandom_range(0, 9)), 12'($urandom)}, pick_wait(), 0, 1, -1);
        default: run_instr({4'($urandom_range(0, 9)), 12'($urandom)}, pick_wait(),
                           pick_wait(), 2, -1);
      endcase
    end

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
